// File: rtl/bitline_loader.sv
// Packs '0'/'1' ASCII lines MSB-first into WIDTH-bit words in RAM, then serves a 1-cycle read port.
// Optional macro BITLINE_LOADER_CR_SKIP_EN: silently skip '\r' so CRLF streams load cleanly.
module bitline_loader #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 1000,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             loaded,
  output logic [AW:0]      count,
  output logic             err_fmt,
  output logic             err_ovf
);
  localparam int NW = $clog2(WIDTH + 2);
  localparam logic [NW-1:0] NFULL = NW'(WIDTH);
  localparam logic [NW-1:0] NSAT  = NW'(WIDTH + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic {LOAD, DONE} state_t;

  state_t           state, state_nxt;
  logic             armed;
  logic             acc, is_digit, is_nl, is_skip;
  logic             commit, fmt_err, wr_en;
  logic [WIDTH-1:0] sr, sr_post, commit_word;
  logic [NW-1:0]    ndig, ndig_post;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= LOAD;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == LOAD && acc && in_last) state_nxt = DONE;
  end

  // armed keeps in_ready low during the reset cycle itself
  always_comb begin
    in_ready = armed && (state == LOAD);
    loaded   = (state == DONE);
  end

  assign acc      = in_valid && in_ready;
  assign is_digit = (in_data == 8'h30) || (in_data == 8'h31);
  assign is_nl    = (in_data == 8'h0A);
`ifdef BITLINE_LOADER_CR_SKIP_EN
  assign is_skip  = (in_data == 8'h0D);
`else
  assign is_skip  = 1'b0;
`endif

  // A '\n' commits the pre-byte word; in_last commits the post-byte word. Only one can fire.
  always_comb begin
    sr_post     = sr;
    ndig_post   = ndig;
    commit      = 1'b0;
    commit_word = sr;
    fmt_err     = 1'b0;
    if (acc) begin
      if (is_digit) begin
        sr_post   = {sr[WIDTH-2:0], in_data[0]};
        ndig_post = (ndig == NSAT) ? NSAT : ndig + 1'b1;
      end else if (is_nl) begin
        if (ndig == NFULL) commit = 1'b1;
        else if (ndig != '0) fmt_err = 1'b1;
        sr_post   = '0;
        ndig_post = '0;
      end else if (!is_skip) begin
        fmt_err = 1'b1;
      end
      if (in_last) begin
        if (ndig_post == NFULL) begin
          commit      = 1'b1;
          commit_word = sr_post;
        end else if (ndig_post != '0) begin
          fmt_err = 1'b1;
        end
      end
    end
  end

  assign wr_en = commit && (count < DEPTH_C);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr      <= '0;
      ndig    <= '0;
      count   <= '0;
      err_fmt <= 1'b0;
      err_ovf <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      sr   <= sr_post;
      ndig <= ndig_post;
      if (fmt_err) err_fmt <= 1'b1;
      if (wr_en) count <= count + 1'b1;
      else if (commit) err_ovf <= 1'b1;
      valid <= loaded && re;
      if (loaded && re) data <= ({1'b0, addr} < count) ? mem[addr] : '0;
    end
  end

  // RAM has no reset; contents survive a restart
  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem[count[AW-1:0]] <= commit_word;
  end

endmodule

// File: tb/tb_bitline_loader.sv
// Directed bench for bitline_loader: instance A (WIDTH=5, DEPTH=8) and instance B (WIDTH=5, DEPTH=2).
module tb_bitline_loader;
  localparam int W   = 5;
  localparam int DA  = 8;
  localparam int DB  = 2;
  localparam int AWA = $clog2(DA);
  localparam int AWB = $clog2(DB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           a_rstn, a_in_valid, a_in_ready, a_in_last, a_re, a_valid, a_loaded, a_err_fmt, a_err_ovf;
  logic [7:0]     a_in_data;
  logic [AWA-1:0] a_addr;
  logic [W-1:0]   a_data;
  logic [AWA:0]   a_count;

  logic           b_rstn, b_in_valid, b_in_ready, b_in_last, b_re, b_valid, b_loaded, b_err_fmt, b_err_ovf;
  logic [7:0]     b_in_data;
  logic [AWB-1:0] b_addr;
  logic [W-1:0]   b_data;
  logic [AWB:0]   b_count;

  int total = 0;
  int bad   = 0;

  bitline_loader #(.WIDTH(W), .DEPTH(DA)) u_a (
    .clk(clk), .rstn(a_rstn), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_last(a_in_last), .re(a_re), .addr(a_addr), .data(a_data), .valid(a_valid),
    .loaded(a_loaded), .count(a_count), .err_fmt(a_err_fmt), .err_ovf(a_err_ovf)
  );

  bitline_loader #(.WIDTH(W), .DEPTH(DB)) u_b (
    .clk(clk), .rstn(b_rstn), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_last(b_in_last), .re(b_re), .addr(b_addr), .data(b_data), .valid(b_valid),
    .loaded(b_loaded), .count(b_count), .err_fmt(b_err_fmt), .err_ovf(b_err_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is taken on the following posedge.
  task automatic send(input bit sel, input logic [7:0] b, input bit last);
    if (!sel) begin
      a_in_data = b; a_in_valid = 1'b1; a_in_last = last;
    end else begin
      b_in_data = b; b_in_valid = 1'b1; b_in_last = last;
    end
    @(negedge clk);
    a_in_valid = 1'b0; a_in_last = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic send_str(input bit sel, input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send(sel, s[i], last && (i == s.len() - 1));
  endtask

  task automatic rd_a(input logic [AWA-1:0] ad);
    a_re = 1'b1; a_addr = ad;
    @(negedge clk);
    a_re = 1'b0;
  endtask

  task automatic rd_b(input logic [AWB-1:0] ad);
    b_re = 1'b1; b_addr = ad;
    @(negedge clk);
    b_re = 1'b0;
  endtask

  task automatic reset_a();
    a_rstn = 1'b0;
    @(negedge clk);
    a_rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rstn = 1'b0; a_in_data = '0; a_in_valid = 1'b0; a_in_last = 1'b0; a_re = 1'b0; a_addr = '0;
    b_rstn = 1'b0; b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_re = 1'b0; b_addr = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_loaded",   a_loaded,   0);
    check("rst_valid",    a_valid,    0);
    check("rst_data",     a_data,     0);
    check("rst_count",    a_count,    0);
    check("rst_err",      {a_err_fmt, a_err_ovf}, 0);
    a_rstn = 1'b1; b_rstn = 1'b1;
    @(negedge clk);
    check("in_ready_up", a_in_ready, 1);

    rd_a(0);
    check("rd_unloaded_valid", a_valid, 0);

    // basic load
    send_str(0, "00100\n11110\n", 0);
    check("t1_mid_count",  a_count,  2);
    check("t1_mid_loaded", a_loaded, 0);
    send_str(0, "10110", 1);
    check("t1_count",    a_count,    3);
    check("t1_loaded",   a_loaded,   1);
    check("t1_in_ready", a_in_ready, 0);
    check("t1_err_fmt",  a_err_fmt,  0);
    check("t1_err_ovf",  a_err_ovf,  0);

    // read port, back-to-back and out-of-range
    rd_a(0); check("t2_d0", a_data, 5'h04); check("t2_v0", a_valid, 1);
    rd_a(1); check("t2_d1", a_data, 5'h1E); check("t2_v1", a_valid, 1);
    rd_a(2); check("t2_d2", a_data, 5'h16);
    rd_a(3); check("t2_d3", a_data, 0);     check("t2_v3", a_valid, 1);
    @(negedge clk);
    check("t2_valid_drop", a_valid, 0);

    // input ignored once loaded
    send(0, 8'h31, 0);
    send(0, 8'h78, 0);
    check("done_count", a_count,   3);
    check("done_fmt",   a_err_fmt, 0);

    // short line dropped
    reset_a();
    check("t3_rst_loaded", a_loaded, 0);
    send_str(0, "0101\n10101\n", 1);
    check("t3_err_fmt", a_err_fmt, 1);
    check("t3_count",   a_count,   1);
    check("t3_loaded",  a_loaded,  1);
    rd_a(0); check("t3_d0", a_data, 5'h15);

    // long line dropped, unterminated final line committed
    reset_a();
    send_str(0, "101010\n00011", 1);
    check("long_err_fmt", a_err_fmt, 1);
    check("long_count",   a_count,   1);
    rd_a(0); check("long_d0", a_data, 5'h03);

    // CRLF line
    reset_a();
    send_str(0, "10101\r\n", 1);
    check("t5_count", a_count, 1);
`ifdef BITLINE_LOADER_CR_SKIP_EN
    check("t5_err_fmt", a_err_fmt, 0);
`else
    check("t5_err_fmt", a_err_fmt, 1);
`endif
    rd_a(0); check("t5_d0", a_data, 5'h15);

    // reset mid-load restarts from address 0
    reset_a();
    send_str(0, "00100\n11110\n", 0);
    check("t6_pre_count", a_count, 2);
    reset_a();
    check("t6_count0",  a_count,    0);
    check("t6_loaded0", a_loaded,   0);
    check("t6_ready",   a_in_ready, 1);
    send_str(0, "00001\n00010\n00011", 1);
    check("t6_count", a_count, 3);
    rd_a(0); check("t6_d0", a_data, 5'h01);
    rd_a(2); check("t6_d2", a_data, 5'h03);

    // overflow on the DEPTH=2 instance
    send_str(1, "00001\n00010\n00011", 1);
    check("t4_count",   b_count,   2);
    check("t4_err_ovf", b_err_ovf, 1);
    check("t4_err_fmt", b_err_fmt, 0);
    check("t4_loaded",  b_loaded,  1);
    rd_b(0); check("t4_d0", b_data, 5'h01);
    rd_b(1); check("t4_d1", b_data, 5'h02); check("t4_v1", b_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
